// File: rtl/bss_pkg.sv
// Shared encodings for the bit-stream sequencer: controller states, toggle-core
// states and the default word width.
package bss_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  typedef enum logic {
    CORE_A = 1'b0,
    CORE_B = 1'b1
  } core_state_e;

endpackage

// File: rtl/toggle_mealy_core.sv
// Two-state Mealy toggle core: a 1 on d emits x=1 from A and x=0 from B,
// flipping state each time; d=0 holds state with x=0.
module toggle_mealy_core
  import bss_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic d,
  output logic x,
  output logic state
);

  core_state_e state_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CORE_A;
    end else if (clr) begin
      state_q <= CORE_A;
    end else if (d) begin
      state_q <= (state_q == CORE_A) ? CORE_B : CORE_A;
    end
  end

  // Mealy output: depends on the current input as well as the state.
  assign x     = d & (state_q == CORE_A);
  assign state = state_q;

endmodule

// File: rtl/bit_stream_sequencer.sv
// Streams a captured word LSB first through the toggle core, collecting the
// per-bit x outputs and their population count into a ready/valid result.
module bit_stream_sequencer
  import bss_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_len,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_ones,
  output logic             core_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ctrl_state_e      ctrl;
  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic             accept;
  logic             d;
  logic             x;

  // Index of the final bit to stream: 0 and anything beyond WIDTH mean WIDTH.
  function automatic logic [IDX_W-1:0] last_index(input logic [3:0] len);
    int n;
    n = int'(len);
    if (n == 0 || n > WIDTH) n = WIDTH;
    return IDX_W'(n - 1);
  endfunction

  assign in_ready = (ctrl == IDLE) & ~reset;
  assign accept   = in_valid & in_ready;
  assign d        = (ctrl == SHIFT) ? data_q[idx] : 1'b0;

  toggle_mealy_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (accept & in_clr),
    .d     (d),
    .x     (x),
    .state (core_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl      <= IDLE;
      data_q    <= '0;
      idx       <= '0;
      last_idx  <= '0;
      out_data  <= '0;
      out_ones  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (ctrl)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            last_idx <= last_index(in_len);
            idx      <= '0;
            out_data <= '0;
            out_ones <= '0;
            ctrl     <= SHIFT;
          end
        end
        SHIFT: begin
          out_data[idx] <= x;
          out_ones      <= out_ones + 4'(x);
          if (idx == last_idx) begin
            ctrl      <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it; in_ready is low
          // here, so a handshake cycle can never also accept a word.
          if (out_ready) begin
            ctrl      <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ctrl <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bit_stream_sequencer.md
BIT_STREAM_SEQUENCER -- requirements
Module: bit_stream_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of bits per word.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a word request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the sequencer accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: word to stream, sent LSB first.
REQ-007 The block SHALL have port in_len, input, 4 bits: number of bits to stream; 0 means WIDTH.
REQ-008 The block SHALL have port in_clr, input, 1 bit: force core state to A at accept.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: x output captured per streamed bit.
REQ-012 The block SHALL have port out_ones, output, 4 bits: count of 1s in out_data.
REQ-013 The block SHALL have port core_state, output, 1 bit: current toggle-core state (0=A, 1=B).

Function
REQ-014 The toggle core SHALL be a Mealy FSM with states A and B: in A with d=1, x=1 and next state B; in B with d=1, x=0 and next state A; with d=0, x=0 and the state holds.
REQ-015 The controller SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, in_valid=1 SHALL capture in_data, the effective length, and in_clr, clear out_data/out_ones, and move to SHIFT next cycle.
REQ-017 An accept with in_clr=1 SHALL set the core to A at that same clock edge.
REQ-018 An accept with in_clr=0 SHALL keep the core state carried from the previous word.
REQ-019 In SHIFT, each cycle SHALL drive d = data[idx] (idx 0..len-1) and SHALL store x into out_data[idx]; the core advances at the edge.
REQ-020 In SHIFT, out_ones SHALL increment by x at each edge.
REQ-021 After the edge for bit len-1, the controller SHALL enter DONE; out_data bits at or above len SHALL be 0.
REQ-022 Latency: for an accept at edge T, out_valid SHALL rise after edge T+len, i.e. len+1 cycles.
REQ-023 Outside SHIFT, d SHALL be 0, so the core holds its state.
REQ-024 In DONE, out_valid SHALL be 1 and out_data/out_ones SHALL be held stable until out_ready=1; that edge SHALL return the controller to IDLE.
REQ-025 No word SHALL be accepted in the same cycle as an output handshake.
REQ-026 in_len values greater than WIDTH SHALL be clamped to WIDTH.

Reset
REQ-027 While reset=1, the block SHALL hold the controller in IDLE, the core in A, out_valid=0, out_data=0, out_ones=0 and in_ready=0, asynchronously.
REQ-028 A reset mid-SHIFT or mid-DONE SHALL abort the word with no output produced; in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-029 Package bss_pkg SHALL hold the controller state encoding (IDLE/SHIFT/DONE), the core state encoding (A=0, B=1) and the default WIDTH.
REQ-030 The toggle core SHALL be a sub-module, toggle_mealy_core (clk, reset, clr, d, x, state), instantiated once.

Verification
REQ-031 Accept 0x0F with len=8 and clr=1 -> out_data=0x05, out_ones=2, out_valid 9 cycles after accept, core_state=A.
REQ-032 Accept 0x01 (len 8, clr=1), then 0x01 (len 8, clr=0) -> first out_data=0x01 with core ending in B; second out_data=0x00 with core ending in A.
REQ-033 Accept 0xFF with len=3 -> out_data=0x05, out_ones=2, out_valid after 4 cycles; len=0 streams 8 bits.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0 throughout; IDLE after out_ready=1.
REQ-035 Assert reset at the 3rd SHIFT cycle -> out_valid=0, core_state=A, in_ready=0 during reset and 1 after release; no result emitted.
